// File: rtl/counter_preset_loader.sv
// rtl/counter_preset_loader.sv - preset FIFO and load sequencer for a 4-bit loadable up counter
// Optional feature: LOADER_AUTO_RELOAD_EN reloads the last popped preset when the FIFO runs dry.
module counter_preset_loader #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [3:0]               in_data,
  output logic                     in_ready,
  input  logic [3:0]               count_in,
  output logic                     load,
  output logic [3:0]               load_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic                     seg_done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   LVL_ONE  = 1;
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        r_state;
  logic [3:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          r_load;
  logic [3:0]    r_load_data;
  logic          r_seg_done;
`ifdef LOADER_AUTO_RELOAD_EN
  logic [3:0]    r_last;
`endif

  logic       w_empty;
  logic       w_full;
  logic       w_push;
  logic       w_detect;
  logic       w_pop;
  logic [3:0] w_head;

  assign w_empty  = (r_level == '0);
  assign w_full   = (r_level == LVL_FULL);
  assign w_push   = in_valid && !w_full;
  assign w_head   = r_mem[r_rd_ptr];
  // The load cycle itself is excluded so a preset of E is not re-detected before it lands.
  assign w_detect = (r_state == S_RUN) && (count_in == 4'hE) && !r_load;
  assign w_pop    = !w_empty && ((r_state == S_IDLE) || w_detect);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_load      <= 1'b0;
      r_load_data <= 4'h0;
      r_seg_done  <= 1'b0;
`ifdef LOADER_AUTO_RELOAD_EN
      r_last      <= 4'h0;
`endif
    end else begin
      r_load     <= 1'b0;
      r_seg_done <= 1'b0;
`ifdef LOADER_AUTO_RELOAD_EN
      if (w_pop) r_last <= w_head;
`endif
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_load      <= 1'b1;
            r_load_data <= w_head;
            r_state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_detect) begin
            if (!w_empty) begin
              r_load      <= 1'b1;
              r_load_data <= w_head;
            end else begin
              r_seg_done <= 1'b1;
`ifdef LOADER_AUTO_RELOAD_EN
              r_load      <= 1'b1;
              r_load_data <= r_last;
`else
              r_state     <= S_IDLE;
`endif
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = !w_full;
  assign load      = r_load;
  assign load_data = r_load_data;
  assign level     = r_level;
  assign busy      = (r_state == S_RUN);
  assign seg_done  = r_seg_done;

endmodule

// File: tb/tb_counter_preset_loader.sv
// tb/tb_counter_preset_loader.sv - directed bench driving a 4-bit loadable counter from the loader
module tb_counter_preset_loader;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic [3:0] cnt;
  logic       load;
  logic [3:0] load_data;
  logic [2:0] level;
  logic       busy;
  logic       seg_done;

  int n_cmp;
  int n_bad;

  counter_preset_loader #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .count_in  (cnt),
    .load      (load),
    .load_data (load_data),
    .level     (level),
    .busy      (busy),
    .seg_done  (seg_done)
  );

  // Downstream counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= 4'h0;
    else if (load) cnt <= load_data;
    else           cnt <= cnt + 4'h1;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic push_one(input logic [3:0] v);
    in_valid = 1'b1;
    in_data  = v;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (load !== 1'b0)      begin n_bad++; $display("FAIL reset_load got %b want 0", load); end
    n_cmp++; if (load_data !== 4'h0) begin n_bad++; $display("FAIL reset_load_data got %h want 0", load_data); end
    n_cmp++; if (level !== 3'd0)     begin n_bad++; $display("FAIL reset_level got %0d want 0", level); end
    n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (seg_done !== 1'b0)  begin n_bad++; $display("FAIL reset_seg_done got %b want 0", seg_done); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single;
    logic [3:0] exp;
    push_one(4'hC);
    n_cmp++; if (level !== 3'd1 || load !== 1'b0) begin n_bad++; $display("FAIL single_pushed level=%0d load=%b want 1,0", level, load); end
    @(negedge clk);
    n_cmp++; if (load !== 1'b1 || load_data !== 4'hC || busy !== 1'b1) begin n_bad++; $display("FAIL single_load load=%b data=%h busy=%b want 1,C,1", load, load_data, busy); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      exp = 4'hC + 4'(i);
      n_cmp++; if (cnt !== exp) begin n_bad++; $display("FAIL single_count[%0d] got %h want %h", i, cnt, exp); end
      n_cmp++; if (seg_done !== (i == 3)) begin n_bad++; $display("FAIL single_seg_done[%0d] got %b want %b", i, seg_done, (i == 3)); end
      n_cmp++; if (load !== 1'b0) begin n_bad++; $display("FAIL single_extra_load[%0d] got %b want 0", i, load); end
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_end got %b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp;
    int segs;
    segs = 0;
    in_valid = 1'b1; in_data = 4'hA;
    @(negedge clk);
    in_data = 4'h5;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (load !== 1'b1 || load_data !== 4'hA || level !== 3'd1) begin n_bad++; $display("FAIL b2b_first_load load=%b data=%h level=%0d want 1,A,1", load, load_data, level); end
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i < 6)       exp = 4'hA + 4'(i);
      else if (i < 17) exp = 4'h5 + 4'(i - 6);
      else             exp = 4'h0;
      if (seg_done) segs++;
      n_cmp++; if (cnt !== exp) begin n_bad++; $display("FAIL b2b_count[%0d] got %h want %h", i, cnt, exp); end
    end
    n_cmp++; if (segs !== 1) begin n_bad++; $display("FAIL b2b_seg_done_count got %0d want 1", segs); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_end got %b want 0", busy); end
  endtask

  task automatic test_full;
    logic [3:0] loads [$];
    int segs;
    segs = 0;
    for (int c = 0; c < 150; c++) begin
      if (load) loads.push_back(load_data);
      if (seg_done) segs++;
      if (c == 5 || c == 7) begin
        n_cmp++; if (level !== 3'd4 || in_ready !== 1'b0) begin n_bad++; $display("FAIL full_level[%0d] level=%0d in_ready=%b want 4,0", c, level, in_ready); end
      end
      in_valid = (c < 7);
      in_data  = (c < 5) ? 4'(c + 1) : 4'h6;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_cmp++; if (loads.size() !== 5) begin n_bad++; $display("FAIL full_load_count got %0d want 5", loads.size()); end
    for (int k = 0; k < 5; k++) begin
      if (k < loads.size()) begin
        n_cmp++; if (loads[k] !== 4'(k + 1)) begin n_bad++; $display("FAIL full_order[%0d] got %h want %h", k, loads[k], 4'(k + 1)); end
      end
    end
    n_cmp++; if (segs !== 1 || busy !== 1'b0 || level !== 3'd0) begin n_bad++; $display("FAIL full_end segs=%0d busy=%b level=%0d want 1,0,0", segs, busy, level); end
  endtask

  task automatic test_edge_presets;
    logic [3:0] exp;
    in_valid = 1'b1; in_data = 4'hF;
    @(negedge clk);
    in_data = 4'hE;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (load !== 1'b1 || load_data !== 4'hF) begin n_bad++; $display("FAIL edge_load_f load=%b data=%h want 1,F", load, load_data); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0)       exp = 4'hF;
      else if (i <= 16) exp = 4'(i - 1);
      else if (i == 17) exp = 4'hE;
      else if (i == 18) exp = 4'hF;
      else              exp = 4'h0;
      n_cmp++; if (cnt !== exp) begin n_bad++; $display("FAIL edge_count[%0d] got %h want %h", i, cnt, exp); end
      n_cmp++; if (seg_done !== (i == 18)) begin n_bad++; $display("FAIL edge_seg_done[%0d] got %b want %b", i, seg_done, (i == 18)); end
    end
  endtask

  task automatic test_reset_mid_run;
    int loads;
    loads = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      in_data  = 4'h7 + 4'(c);
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_cmp++; if (level !== 3'd3 || busy !== 1'b1) begin n_bad++; $display("FAIL midrst_setup level=%0d busy=%b want 3,1", level, busy); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (level !== 3'd0 || load !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_async level=%0d load=%b busy=%b in_ready=%b want 0,0,0,1", level, load, busy, in_ready); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (load) loads++;
    end
    n_cmp++; if (loads !== 0) begin n_bad++; $display("FAIL midrst_no_loads got %0d want 0", loads); end
  endtask

  task automatic test_auto_reload;
    logic [3:0] exp;
    push_one(4'h3);
    @(negedge clk);
    n_cmp++; if (load !== 1'b1 || load_data !== 4'h3) begin n_bad++; $display("FAIL auto_first_load load=%b data=%h want 1,3", load, load_data); end
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      exp = 4'h3 + 4'(i % 13);
      n_cmp++; if (cnt !== exp) begin n_bad++; $display("FAIL auto_count[%0d] got %h want %h", i, cnt, exp); end
      n_cmp++; if (seg_done !== ((i % 13) == 12)) begin n_bad++; $display("FAIL auto_seg_done[%0d] got %b want %b", i, seg_done, ((i % 13) == 12)); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL auto_busy[%0d] got %b want 1", i, busy); end
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 4'h0;
    test_reset();
`ifdef LOADER_AUTO_RELOAD_EN
    test_auto_reload();
`else
    test_single();
    test_back_to_back();
    test_full();
    test_edge_presets();
    test_reset_mid_run();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
